// File: rtl/mtx_pkg.sv
// Shared constants for the elementwise multiplier, its loader and the result serializer.
// Matrices travel as flat vectors with element k at bits [k*OW +: OW].
package mtx_pkg;

    localparam int MTX_W   = 8;
    localparam int MTX_N   = 16;
    localparam int MTX_OW  = 2 * MTX_W;
    localparam int MTX_IW  = $clog2(MTX_N);
    localparam int MTX_DIM = 4;

    typedef logic [MTX_OW-1:0]        mtx_elem_t;
    typedef logic [MTX_N*MTX_OW-1:0]  mtx_flat_t;

    function automatic int elem_lsb(input int k, input int ow);
        return k * ow;
    endfunction

    function automatic mtx_elem_t mtx_elem(input mtx_flat_t m, input int k);
        return m[elem_lsb(k, MTX_OW) +: MTX_OW];
    endfunction

endpackage

// File: rtl/mtx_slot_buf.sv
// Two-slot matrix store: one slot can fill while the other drains.
// A write into a full buffer is ignored; the writer must hold its data.
module mtx_slot_buf
    import mtx_pkg::*;
#(
    parameter int DW = MTX_N * MTX_OW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_pop,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] slot [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          wr_fire;
    logic          pop_fire;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign wr_fire  = wr_en && !full;
    assign pop_fire = rd_pop && !empty;
    assign rd_data  = slot[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_fire) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({wr_fire, pop_fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Slot contents need no reset: they are only observed while count marks them valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            slot[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/mtx_result_serializer.sv
// Streams captured 4x4 product matrices out one element per beat, row-major.
// The slot buffer holds up to two matrices so capture and drain overlap without bubbles.
module mtx_result_serializer
    import mtx_pkg::*;
#(
    parameter int W = MTX_W,
    parameter int N = MTX_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N*2*W-1:0]      i_mtx_m,
    input  logic                  i_valid,
    output logic                  o_in_ready,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2*W-1:0]        o_data,
    output logic [$clog2(N)-1:0]  o_idx,
    output logic                  o_last,
    output logic                  o_done
);

    localparam int             OW       = 2 * W;
    localparam int             IW       = $clog2(N);
    localparam logic [IW-1:0]  IDX_LAST = IW'(N - 1);

    logic [IW-1:0]   idx;
    logic            done_q;
    logic            full;
    logic            empty;
    logic [N*OW-1:0] rd_mtx;
    logic            beat;
    logic            last_beat;

    mtx_slot_buf #(
        .DW (N * OW)
    ) u_slot_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (i_valid),
        .wr_data (i_mtx_m),
        .rd_pop  (last_beat),
        .full    (full),
        .empty   (empty),
        .rd_data (rd_mtx)
    );

    assign o_in_ready = !full;
    assign o_valid    = !empty;
    assign beat       = o_valid && i_ready;
    assign last_beat  = beat && (idx == IDX_LAST);

    // idx wraps at N-1 explicitly so non-power-of-two N still works.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_beat;
            if (beat) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
        end
    end

    // Read slot only changes on the last beat, so a capture into the other slot cannot disturb o_data.
    assign o_data = o_valid ? rd_mtx[elem_lsb(int'(idx), OW) +: OW] : '0;
    assign o_idx  = idx;
    assign o_last = o_valid && (idx == IDX_LAST);
    assign o_done = done_q;

endmodule

// File: tb/tb_mtx_result_serializer.sv
// Directed bench for mtx_result_serializer: single matrix, backpressure,
// back-to-back capture, full buffer, mid-stream reset and capture on the last beat.
module tb_mtx_result_serializer;
    import mtx_pkg::*;

    logic                      clk;
    logic                      rst;
    logic [MTX_N*MTX_OW-1:0]   i_mtx_m;
    logic                      i_valid;
    logic                      o_in_ready;
    logic                      o_valid;
    logic                      i_ready;
    logic [MTX_OW-1:0]         o_data;
    logic [MTX_IW-1:0]         o_idx;
    logic                      o_last;
    logic                      o_done;

    int n_cmp;
    int n_err;

    mtx_result_serializer #(.W(MTX_W), .N(MTX_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_mtx_m    (i_mtx_m),
        .i_valid    (i_valid),
        .o_in_ready (o_in_ready),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_idx      (o_idx),
        .o_last     (o_last),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Element value for each stimulus matrix kind.
    function automatic logic [15:0] exp_elem(input int kind, input int k);
        case (kind)
            0: exp_elem = 16'(((k % 4) + 1) * ((k % 4) + 1));
            1: exp_elem = 16'h0001;
            2: exp_elem = 16'hFE01;
            3: exp_elem = 16'h0011;
            4: exp_elem = 16'h0022;
            5: exp_elem = 16'h0033;
            6: exp_elem = 16'(k + 1);
            7: exp_elem = 16'(16'h0100 + k);
            8: exp_elem = 16'(16'h0A00 + k);
            default: exp_elem = 16'(16'h0B00 + k);
        endcase
    endfunction

    function automatic logic [MTX_N*MTX_OW-1:0] mk_mtx(input int kind);
        logic [MTX_N*MTX_OW-1:0] m;
        m = '0;
        for (int k = 0; k < MTX_N; k++) m[k*16 +: 16] = exp_elem(kind, k);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_mtx_m = '0;
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_data !== 16'h0 ||
            o_idx !== 4'd0 || o_last !== 1'b0 || o_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset: valid=%b in_ready=%b data=%h idx=%0d last=%b done=%b want 0 1 0000 0 0 0",
                     o_valid, o_in_ready, o_data, o_idx, o_last, o_done);
        end
    endtask

    task automatic test_single();
        i_ready = 1'b1; i_valid = 1'b1; i_mtx_m = mk_mtx(0);
        tick();
        i_valid = 1'b0; i_mtx_m = '0;
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (o_valid !== 1'b1 || o_idx !== 4'(k) || o_data !== exp_elem(0, k) ||
                o_last !== (k == 15) || o_done !== 1'b0) begin
                n_err++;
                $display("FAIL single beat %0d: valid=%b idx=%0d data=%h last=%b done=%b want data=%h",
                         k, o_valid, o_idx, o_data, o_last, o_done, exp_elem(0, k));
            end
            tick();
        end
        n_cmp++;
        if (o_done !== 1'b1 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single end: done=%b valid=%b want 1 0", o_done, o_valid);
        end
        tick();
        n_cmp++;
        if (o_done !== 1'b0) begin
            n_err++;
            $display("FAIL single done_pulse: done=%b want 0", o_done);
        end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0; i_valid = 1'b1; i_mtx_m = mk_mtx(0);
        tick();
        i_valid = 1'b0; i_mtx_m = '0;
        for (int cyc = 0; cyc < 32; cyc++) begin
            i_ready = (cyc % 2 == 1);
            n_cmp++;
            if (o_valid !== 1'b1 || o_idx !== 4'(cyc / 2) || o_data !== exp_elem(0, cyc / 2) ||
                o_last !== (cyc / 2 == 15)) begin
                n_err++;
                $display("FAIL backpressure cyc %0d: valid=%b idx=%0d data=%h last=%b want idx=%0d data=%h",
                         cyc, o_valid, o_idx, o_data, o_last, cyc / 2, exp_elem(0, cyc / 2));
            end
            tick();
        end
        n_cmp++;
        if (o_valid !== 1'b0 || o_done !== 1'b1) begin
            n_err++;
            $display("FAIL backpressure end: valid=%b done=%b want 0 1", o_valid, o_done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b1; i_valid = 1'b1; i_mtx_m = mk_mtx(1);
        tick();
        for (int cyc = 0; cyc < 32; cyc++) begin
            if (cyc == 0) begin
                i_valid = 1'b1; i_mtx_m = mk_mtx(2);
                n_cmp++;
                if (o_in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b in_ready: got %b want 1", o_in_ready);
                end
            end else begin
                i_valid = 1'b0; i_mtx_m = '0;
            end
            n_cmp++;
            if (o_valid !== 1'b1 || o_idx !== 4'(cyc % 16) ||
                o_data !== ((cyc < 16) ? 16'h0001 : 16'hFE01) || o_done !== (cyc == 16)) begin
                n_err++;
                $display("FAIL b2b cyc %0d: valid=%b idx=%0d data=%h done=%b want idx=%0d data=%h done=%b",
                         cyc, o_valid, o_idx, o_data, o_done, cyc % 16,
                         (cyc < 16) ? 16'h0001 : 16'hFE01, cyc == 16);
            end
            tick();
        end
        n_cmp++;
        if (o_valid !== 1'b0 || o_done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b end: valid=%b done=%b want 0 1", o_valid, o_done);
        end
        tick();
    endtask

    task automatic test_full();
        i_ready = 1'b0; i_valid = 1'b1; i_mtx_m = mk_mtx(3);
        tick();
        i_mtx_m = mk_mtx(4);
        tick();
        i_mtx_m = mk_mtx(5);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (o_in_ready !== 1'b0 || o_valid !== 1'b1 || o_idx !== 4'd0 || o_data !== 16'h0011) begin
                n_err++;
                $display("FAIL full hold %0d: in_ready=%b valid=%b idx=%0d data=%h want 0 1 0 0011",
                         c, o_in_ready, o_valid, o_idx, o_data);
            end
            tick();
        end
        i_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (o_in_ready !== 1'b0 || o_idx !== 4'(k) || o_data !== 16'h0011 || o_last !== (k == 15)) begin
                n_err++;
                $display("FAIL full drainA %0d: in_ready=%b idx=%0d data=%h last=%b want 0 %0d 0011",
                         k, o_in_ready, o_idx, o_data, o_last, k);
            end
            tick();
        end
        n_cmp++;
        if (o_in_ready !== 1'b1 || o_idx !== 4'd0 || o_data !== 16'h0022 || o_done !== 1'b1) begin
            n_err++;
            $display("FAIL full after A: in_ready=%b idx=%0d data=%h done=%b want 1 0 0022 1",
                     o_in_ready, o_idx, o_data, o_done);
        end
        tick();
        i_valid = 1'b0; i_mtx_m = '0;
        n_cmp++;
        if (o_in_ready !== 1'b0 || o_idx !== 4'd1 || o_data !== 16'h0022) begin
            n_err++;
            $display("FAIL full C captured: in_ready=%b idx=%0d data=%h want 0 1 0022",
                     o_in_ready, o_idx, o_data);
        end
        for (int cyc = 0; cyc < 31; cyc++) begin
            n_cmp++;
            if (o_valid !== 1'b1 || o_idx !== 4'((cyc + 1) % 16) ||
                o_data !== ((cyc < 15) ? 16'h0022 : 16'h0033)) begin
                n_err++;
                $display("FAIL full drainBC %0d: valid=%b idx=%0d data=%h", cyc, o_valid, o_idx, o_data);
            end
            tick();
        end
        n_cmp++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full end: valid=%b want 0", o_valid);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        i_ready = 1'b1; i_valid = 1'b1; i_mtx_m = mk_mtx(6);
        tick();
        i_mtx_m = mk_mtx(7);
        tick();
        i_valid = 1'b0; i_mtx_m = '0;
        repeat (6) tick();
        n_cmp++;
        if (o_idx !== 4'd7 || o_in_ready !== 1'b0 || o_data !== 16'h0008) begin
            n_err++;
            $display("FAIL reset setup: idx=%0d in_ready=%b data=%h want 7 0 0008", o_idx, o_in_ready, o_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_idx !== 4'd0 || o_data !== 16'h0) begin
            n_err++;
            $display("FAIL reset mid: valid=%b in_ready=%b idx=%0d data=%h want 0 1 0 0000",
                     o_valid, o_in_ready, o_idx, o_data);
        end
        for (int c = 0; c < 20; c++) begin
            n_cmp++;
            if (o_done !== 1'b0 || o_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset quiet %0d: done=%b valid=%b want 0 0", c, o_done, o_valid);
            end
            tick();
        end
        i_valid = 1'b1; i_mtx_m = mk_mtx(7);
        tick();
        i_valid = 1'b0; i_mtx_m = '0;
        n_cmp++;
        if (o_valid !== 1'b1 || o_idx !== 4'd0 || o_data !== 16'h0100) begin
            n_err++;
            $display("FAIL reset fresh: valid=%b idx=%0d data=%h want 1 0 0100", o_valid, o_idx, o_data);
        end
        repeat (16) tick();
        n_cmp++;
        if (o_done !== 1'b1 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset fresh end: done=%b valid=%b want 1 0", o_done, o_valid);
        end
        tick();
    endtask

    task automatic test_capture_on_last();
        i_ready = 1'b1; i_valid = 1'b1; i_mtx_m = mk_mtx(8);
        tick();
        i_valid = 1'b0; i_mtx_m = '0;
        repeat (15) tick();
        n_cmp++;
        if (o_in_ready !== 1'b1 || o_last !== 1'b1 || o_data !== 16'h0A0F) begin
            n_err++;
            $display("FAIL col last: in_ready=%b last=%b data=%h want 1 1 0a0f", o_in_ready, o_last, o_data);
        end
        i_valid = 1'b1; i_mtx_m = mk_mtx(9);
        tick();
        i_valid = 1'b0; i_mtx_m = '0;
        n_cmp++;
        if (o_in_ready !== 1'b1 || o_valid !== 1'b1 || o_idx !== 4'd0 ||
            o_data !== 16'h0B00 || o_done !== 1'b1) begin
            n_err++;
            $display("FAIL col next: in_ready=%b valid=%b idx=%0d data=%h done=%b want 1 1 0 0b00 1",
                     o_in_ready, o_valid, o_idx, o_data, o_done);
        end
        repeat (16) tick();
        n_cmp++;
        if (o_valid !== 1'b0 || o_done !== 1'b1) begin
            n_err++;
            $display("FAIL col end: valid=%b done=%b want 0 1", o_valid, o_done);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_full();
        test_mid_reset();
        test_capture_on_last();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
